// File: rtl/core_mailbox.sv
// core_mailbox: per-core message port on a shared one-wire serial bus.
// TX serialises {start, target, payload} after winning bus arbitration.
// RX deserialises frames seen on the bus. Frames addressed to this core,
// or to the broadcast address, are queued in a show-ahead FIFO.
module core_mailbox #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int ARB_TIMEOUT = 256,
    parameter bit BCAST_EN    = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cmd_valid,
    input  logic [1:0]                         cmd_op,
    input  logic [DATA_W-1:0]                  cmd_arg,
    output logic                               cmd_ready,
    input  logic                               recv_req,
    input  logic                               rd_en,
    output logic [DATA_W-1:0]                  rd_data,
    output logic                               rx_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_count,
    output logic                               rx_overflow,
    output logic                               core_hlt,
    output logic                               tx_abort,
    output logic                               arb_req,
    input  logic                               arb_gnt,
    input  logic                               bus_in,
    output logic                               bus_out,
    output logic                               bus_oe
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int RX_BITS = ADDR_W + DATA_W;
    localparam int CNT_MAX = (ARB_TIMEOUT > FRAME_W) ? ARB_TIMEOUT : FRAME_W;
    localparam int TXC_W   = $clog2(CNT_MAX + 1);
    localparam int RXC_W   = $clog2(RX_BITS + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] OP_SET_MY  = 2'd1;
    localparam logic [1:0] OP_SET_TGT = 2'd2;
    localparam logic [1:0] OP_SEND    = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_SEND = 2'd2,
        TX_GAP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_e;

    // ---------------- address registers ----------------
    logic [ADDR_W-1:0] my_addr_q, my_addr_d;
    logic [ADDR_W-1:0] tgt_addr_q, tgt_addr_d;

    // ---------------- transmitter state ----------------
    tx_state_e          tx_state_q, tx_state_d;
    logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [FRAME_W-1:0] tx_sr_q, tx_sr_d;
    logic               tx_abort_q, tx_abort_d;
    logic               send_acc;

    // ---------------- receiver state ----------------
    rx_state_e          rx_state_q, rx_state_d;
    logic [RXC_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [RX_BITS-1:0] rx_sr_q, rx_sr_d;
    logic [ADDR_W-1:0]  rx_addr;
    logic [DATA_W-1:0]  rx_payload;
    logic               addr_match;
    logic               push_req;

    // ---------------- FIFO state ----------------
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               fifo_full;
    logic               do_push;
    logic               do_pop;

    // SET commands are always taken; cmd_ready only gates SEND.
    always_comb begin
        my_addr_d  = my_addr_q;
        tgt_addr_d = tgt_addr_q;
        if (cmd_valid && (cmd_op == OP_SET_MY)) begin
            my_addr_d = cmd_arg[ADDR_W-1:0];
        end
        if (cmd_valid && (cmd_op == OP_SET_TGT)) begin
            tgt_addr_d = cmd_arg[ADDR_W-1:0];
        end
    end

    assign send_acc = cmd_valid && (cmd_op == OP_SEND) && (tx_state_q == TX_IDLE);

    // TX next-state: arbitration with timeout, then a fixed-length frame and a one-cycle gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_sr_d    = tx_sr_q;
        tx_abort_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (send_acc) begin
                    tx_state_d = TX_REQ;
                    tx_cnt_d   = '0;
                    // bit 0 goes out first: start bit, then target LSB-first, then payload LSB-first
                    tx_sr_d    = {cmd_arg, tgt_addr_q, 1'b1};
                end
            end
            TX_REQ: begin
                if (arb_gnt) begin
                    tx_state_d = TX_SEND;
                    tx_cnt_d   = '0;
                end else if (tx_cnt_q == TXC_W'(ARB_TIMEOUT - 1)) begin
                    tx_state_d = TX_IDLE;
                    tx_abort_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + TXC_W'(1);
                end
            end
            TX_SEND: begin
                // grant is not re-checked here: a started frame always completes
                tx_sr_d = {1'b0, tx_sr_q[FRAME_W-1:1]};
                if (tx_cnt_q == TXC_W'(FRAME_W - 1)) begin
                    tx_state_d = TX_GAP;
                end else begin
                    tx_cnt_d = tx_cnt_q + TXC_W'(1);
                end
            end
            TX_GAP: begin
                tx_state_d = TX_IDLE;
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    assign cmd_ready = (tx_state_q == TX_IDLE);
    assign arb_req   = (tx_state_q == TX_REQ) || (tx_state_q == TX_SEND);
    assign bus_oe    = (tx_state_q == TX_SEND);
    assign bus_out   = bus_oe & tx_sr_q[0];
    assign tx_abort  = tx_abort_q;

    // RX next-state: start bit detect (never on our own drive), shift, one address-check cycle.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_sr_d    = rx_sr_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (bus_in && !bus_oe) begin
                    rx_state_d = RX_SHIFT;
                    rx_cnt_d   = '0;
                end
            end
            RX_SHIFT: begin
                // shift in at the top so the first bit received lands in bit 0
                rx_sr_d = {bus_in, rx_sr_q[RX_BITS-1:1]};
                if (rx_cnt_q == RXC_W'(RX_BITS - 1)) begin
                    rx_state_d = RX_CHECK;
                end else begin
                    rx_cnt_d = rx_cnt_q + RXC_W'(1);
                end
            end
            RX_CHECK: begin
                rx_state_d = RX_IDLE;
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    assign rx_addr    = rx_sr_q[ADDR_W-1:0];
    assign rx_payload = rx_sr_q[RX_BITS-1:ADDR_W];
    assign addr_match = (rx_addr == my_addr_q) || (BCAST_EN && (&rx_addr));
    assign push_req   = (rx_state_q == RX_CHECK) && addr_match;

    assign fifo_full = (count_q == OCC_W'(FIFO_DEPTH));
    assign do_pop    = rd_en && (count_q != '0);
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_push   = push_req && (!fifo_full || do_pop);

    // FIFO pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + OCC_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - OCC_W'(1);
        end
        if (push_req && !do_push) begin
            ovf_d = 1'b1;
        end
    end

    assign rx_empty    = (count_q == '0);
    assign rx_count    = count_q;
    assign rx_overflow = ovf_q;
    assign rd_data     = rx_empty ? '0 : mem_q[rd_ptr_q];
    assign core_hlt    = recv_req & rx_empty;

    // Control registers: FSMs, counters, addresses, FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            my_addr_q  <= '0;
            tgt_addr_q <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_abort_q <= 1'b0;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            my_addr_q  <= my_addr_d;
            tgt_addr_q <= tgt_addr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_abort_q <= tx_abort_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Datapath registers: shift registers only matter while their FSM says so.
    always_ff @(posedge clk) begin
        tx_sr_q <= tx_sr_d;
        rx_sr_q <= rx_sr_d;
    end

    // FIFO storage write; the read side is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= rx_payload;
        end
    end

endmodule
